imem_boot_loader: RTL and testbench

- Sits directly upstream of the single-cycle RISC-V core and its instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes them to consecutive IMEM word addresses starting at 0.
- Holds the core in reset until the full image and its checksum have been accepted, then releases it. This replaces bench-side forcing of the PC and memory contents.

---
 rtl/imem_boot_loader_if.sv | 31 +++
 rtl/imem_boot_loader.sv | 188 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream ingress and IMEM write bus shared by the boot loader and its environment.
// The slave view is the loader. The master view is the byte source that also observes IMEM writes.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  imem_wr_en;
  logic [ADDR_WIDTH-1:0] imem_wr_addr;
  logic [DATA_WIDTH-1:0] imem_wr_data;

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output imem_wr_en,
    output imem_wr_addr,
    output imem_wr_data
  );

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  imem_wr_en,
    input  imem_wr_addr,
    input  imem_wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into IMEM as little-endian words.
// The core is held in reset until the whole image and its checksum have been accepted.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  input  logic                reload,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            acc_q, acc_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  core_reset_q, core_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic                  in_ready;
  logic                  xfer;
  logic [16:0]           len_full;
  logic [ADDR_WIDTH:0]   words_inc;
  logic [DATA_WIDTH-1:0] word_next;

  function automatic logic [DATA_WIDTH-1:0] insert_byte(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            idx,
    input logic [7:0]            b
  );
    logic [DATA_WIDTH-1:0] r;
    r              = w;
    r[8*idx +: 8]  = b;
    return r;
  endfunction

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN0, S_LEN1, S_DATA, S_CHK: in_ready = 1'b1;
      default:                       in_ready = 1'b0;
    endcase
  end

  assign xfer      = bus.in_valid && in_ready;
  // Length candidate combines the byte on the bus with the latched low byte.
  assign len_full  = {1'b0, bus.in_byte, len_q[7:0]};
  assign words_inc = words_q + 1'b1;
  assign word_next = insert_byte(word_q, byte_idx_q, bus.in_byte);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    acc_d        = acc_q;
    words_d      = words_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_reset_d = 1'b1;
    load_done_d  = 1'b0;
    load_error_d = 1'b0;

    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = bus.in_byte;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = bus.in_byte;
          if (len_full == 17'd0 || len_full > CAPACITY) state_d = S_ERR;
          else                                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = word_next;
          acc_d  = acc_q ^ bus.in_byte;
          if (byte_idx_q == 2'd3) begin
            // Strobe, address and data are registered together so they align in S_WRITE.
            byte_idx_d = 2'd0;
            state_d    = S_WRITE;
            wr_en_d    = 1'b1;
            wr_addr_d  = words_q[ADDR_WIDTH-1:0];
            wr_data_d  = word_next;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        if (17'(words_inc) == {1'b0, len_q}) state_d = S_CHK;
        else                                 state_d = S_DATA;
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.in_byte == acc_q) state_d = S_RUN;
          else                      state_d = S_ERR;
        end
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d    = S_LEN0;
          words_d    = '0;
          acc_d      = '0;
          byte_idx_d = '0;
        end
      end
      default: state_d = S_LEN0;
    endcase

    // Status follows the current state one edge later; reload overrides immediately.
    if (state_q == S_RUN && !reload) begin
      core_reset_d = 1'b0;
      load_done_d  = 1'b1;
    end
    if (state_q == S_ERR && !reload) begin
      load_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_LEN0;
      len_q        <= '0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      acc_q        <= '0;
      words_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      acc_q        <= acc_d;
      words_q      <= words_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_wr_addr = wr_addr_q;
  assign bus.imem_wr_data = wr_data_q;
  assign core_reset       = core_reset_q;
  assign load_done        = load_done_q;
  assign load_error       = load_error_q;
  assign words_loaded     = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: random byte images scored against an image-level reference model.
module tb_imem_boot_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          reload;
  logic          core_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  imem_boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .reload       (reload),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  logic [31:0] img[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset === 1'b0 && bus.imem_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%08h", bus.imem_wr_addr, bus.imem_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.imem_wr_addr !== e.addr || bus.imem_wr_data !== e.data) begin
          failures++;
          $display("FAIL imem_write actual=%0h:%08h expected=%0h:%08h",
                   bus.imem_wr_addr, bus.imem_wr_data, e.addr, e.data);
        end
      end
      check("in_ready_during_write", bus.in_ready, 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_timeout actual=in_ready_low required=accept byte=%02h", b);
      bus.in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_core_reset", core_reset, 1'b1);
    check("reload_load_done", load_done, 1'b0);
    check("reload_load_error", load_error, 1'b0);
    check("reload_words", words_loaded, 0);
    check("reload_in_ready", bus.in_ready, 1'b1);
  endtask

  // Reference: an image is written word by word when its length fits; it runs only if
  // the checksum byte equals the XOR of all data bytes. chk_val < 0 means send the right one.
  task automatic run_image(input int len, input int chk_val, input int gapmax);
    logic [15:0] l;
    logic [31:0] w;
    logic [7:0]  b, acc, chkb;
    bit          len_ok, ok;
    int          exp_words;
    wr_t         e;
    l      = 16'(len);
    len_ok = (len != 0) && (len <= (1 << AW));
    send_byte(l[7:0], $urandom_range(0, gapmax));
    send_byte(l[15:8], $urandom_range(0, gapmax));
    check("core_reset_during_load", core_reset, 1'b1);
    check("load_done_during_load", load_done, 1'b0);
    acc = 8'h00;
    ok  = 1'b0;
    exp_words = 0;
    if (len_ok) begin
      for (int i = 0; i < len; i++) begin
        w      = img[i];
        e.addr = AW'(i);
        e.data = w;
        exp_q.push_back(e);
        for (int j = 0; j < 4; j++) begin
          b   = w[8*j +: 8];
          acc = acc ^ b;
          send_byte(b, $urandom_range(0, gapmax));
        end
      end
      chkb = (chk_val < 0) ? acc : 8'(chk_val);
      send_byte(chkb, $urandom_range(0, gapmax));
      ok        = (chkb == acc);
      exp_words = len;
    end
    bus.in_valid = 1'b0;
    check("core_reset_at_entry", core_reset, 1'b1);
    @(negedge clk);
    check("core_reset_final", core_reset, ok ? 1'b0 : 1'b1);
    check("load_done_final", load_done, ok ? 1'b1 : 1'b0);
    check("load_error_final", load_error, ok ? 1'b0 : 1'b1);
    check("words_loaded_final", words_loaded, exp_words);
    check("in_ready_final", bus.in_ready, 1'b0);
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_load_done", load_done, 1'b0);
    check("rst_load_error", load_error, 1'b0);
    check("rst_wr_en", bus.imem_wr_en, 1'b0);
    check("rst_wr_addr", bus.imem_wr_addr, 0);
    check("rst_wr_data", bus.imem_wr_data, 0);
    check("rst_words", words_loaded, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Two-word program, correct checksum, then the same with a wrong checksum.
    img = '{32'h00500093, 32'h00A00113};
    run_image(2, -1, 0);
    do_reload();
    run_image(2, 8'hD1, 0);

    // Illegal lengths go straight to error.
    do_reload();
    run_image(0, -1, 0);
    do_reload();
    run_image(257, -1, 0);

    // Full capacity image exercises the last address and the widest word count.
    do_reload();
    img.delete();
    for (int i = 0; i < (1 << AW); i++) img.push_back($urandom);
    run_image(1 << AW, -1, 0);

    // Random images with random idle gaps; some carry a corrupted checksum.
    for (int k = 0; k < 8; k++) begin
      int n;
      int cv;
      do_reload();
      n = (k < 3) ? 4 : $urandom_range(1, 6);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      cv = -1;
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        cv = int'(x ^ (8'h01 << $urandom_range(0, 7)));
      end
      run_image(n, cv, 5);
    end

    // Reset in the middle of a load, then a fresh one-word image from address 0.
    do_reload();
    begin
      wr_t   e;
      logic [31:0] w0, w1;
      w0 = $urandom;
      w1 = $urandom;
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      e.addr = '0;
      e.data = w0;
      exp_q.push_back(e);
      for (int j = 0; j < 4; j++) send_byte(w0[8*j +: 8], 1);
      for (int j = 0; j < 2; j++) send_byte(w1[8*j +: 8], 1);
      bus.in_valid = 1'b0;
      check("midload_writes_done", exp_q.size(), 0);
      reset = 1'b1;
      #1;
      check("midload_rst_words", words_loaded, 0);
      check("midload_rst_core_reset", core_reset, 1'b1);
      check("midload_rst_wr_addr", bus.imem_wr_addr, 0);
      check("midload_rst_wr_data", bus.imem_wr_data, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midload_in_ready", bus.in_ready, 1'b1);
    end
    img = '{32'hDEADBEEF};
    run_image(1, -1, 2);

    // Reload from run with the single-instruction image 13 00 00 00, checksum 13.
    do_reload();
    img = '{32'h00000013};
    run_image(1, 8'h13, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
